// File: rtl/pci_bus_requester.sv
// Initiator-side bus agent: turns one local transfer command into a bus tenure
// (request, wait for grant on an idle bus, drive frame for the beats, report outcome).
module pci_bus_requester #(
  parameter int LEN_W     = 4,
  parameter int TIMEOUT   = 16,
  parameter int LAT_TIMER = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             pci_grnt,
  input  logic             pci_frame_in,
  output logic             pci_req,
  output logic             pci_frame,
  output logic             done,
  output logic [1:0]       done_status,
  output logic [LEN_W-1:0] beats_left
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int LAT_W  = $clog2(LAT_TIMER + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT);
  localparam logic [LAT_W-1:0]  LAT_LIM  = LAT_W'(LAT_TIMER);
  localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};
  localparam logic [LAT_W-1:0]  LAT_MAX  = {LAT_W{1'b1}};

  localparam logic [1:0] ST_COMPLETE  = 2'b00;
  localparam logic [1:0] ST_PREEMPTED = 2'b01;
  localparam logic [1:0] ST_TIMEOUT   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_TURN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              ready_q, ready_d;
  logic              req_q, req_d;
  logic              frame_q, frame_d;
  logic              done_q, done_d;
  logic [1:0]        status_q, status_d;

  logic [WAIT_W-1:0] wait_inc;
  logic [LAT_W-1:0]  lat_inc;
  logic [LEN_W-1:0]  beats_dec;

  // Next-state and next-output computation; outputs are derived from the state being entered.
  always_comb begin
    state_d   = state_q;
    beats_d   = beats_q;
    wait_d    = wait_q;
    lat_d     = lat_q;
    status_d  = status_q;
    ready_d   = 1'b0;
    req_d     = 1'b0;
    frame_d   = 1'b0;
    done_d    = 1'b0;
    wait_inc  = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
    lat_inc   = (lat_q == LAT_MAX) ? lat_q : lat_q + 1'b1;
    beats_dec = (beats_q == {LEN_W{1'b0}}) ? beats_q : beats_q - 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          beats_d  = cmd_len;
          wait_d   = {WAIT_W{1'b0}};
          lat_d    = {LAT_W{1'b0}};
          status_d = ST_COMPLETE;
          if (cmd_len != {LEN_W{1'b0}}) begin
            state_d = S_REQ;
            req_d   = 1'b1;
          end else begin
            state_d = S_TURN;
            done_d  = 1'b1;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      S_REQ: begin
        wait_d = wait_inc;
        // A usable grant beats a timeout landing on the same edge.
        if (pci_grnt && !pci_frame_in) begin
          state_d = S_XFER;
          lat_d   = {LAT_W{1'b0}};
          req_d   = 1'b1;
          frame_d = 1'b1;
        end else if (wait_inc >= WAIT_LIM) begin
          state_d  = S_TURN;
          status_d = ST_TIMEOUT;
          done_d   = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      S_XFER: begin
        beats_d = beats_dec;
        lat_d   = lat_inc;
        if (beats_dec == {LEN_W{1'b0}}) begin
          state_d  = S_TURN;
          status_d = ST_COMPLETE;
          done_d   = 1'b1;
        end else if (!pci_grnt && (lat_inc >= LAT_LIM)) begin
          state_d  = S_TURN;
          status_d = ST_PREEMPTED;
          done_d   = 1'b1;
        end else begin
          req_d   = 1'b1;
          frame_d = 1'b1;
        end
      end
      S_TURN: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      beats_q  <= {LEN_W{1'b0}};
      wait_q   <= {WAIT_W{1'b0}};
      lat_q    <= {LAT_W{1'b0}};
      ready_q  <= 1'b1;
      req_q    <= 1'b0;
      frame_q  <= 1'b0;
      done_q   <= 1'b0;
      status_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      beats_q  <= beats_d;
      wait_q   <= wait_d;
      lat_q    <= lat_d;
      ready_q  <= ready_d;
      req_q    <= req_d;
      frame_q  <= frame_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign pci_req     = req_q;
  assign pci_frame   = frame_q;
  assign done        = done_q;
  assign done_status = status_q;
  assign beats_left  = beats_q;

endmodule

// File: tb/tb_pci_bus_requester.sv
// Directed bench for pci_bus_requester: expected tenure outcomes are queued at
// command time and popped when done pulses; cycle counts are checked per tenure.
module tb_pci_bus_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_len;
  logic       pci_grnt;
  logic       pci_frame_in;
  logic       pci_req;
  logic       pci_frame;
  logic       done;
  logic [1:0] done_status;
  logic [3:0] beats_left;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] beats;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pci_bus_requester #(.LEN_W(4), .TIMEOUT(16), .LAT_TIMER(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_len      (cmd_len),
    .pci_grnt     (pci_grnt),
    .pci_frame_in (pci_frame_in),
    .pci_req      (pci_req),
    .pci_frame    (pci_frame),
    .done         (done),
    .done_status  (done_status),
    .beats_left   (beats_left)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command: grant policy, busy-bus cycles, grant drop point and expected outcome.
  task automatic tenure(input string name, input int len, input bit grant, input int busy,
                        input int drop_after, input int exp_req, input int exp_frame,
                        input logic [1:0] exp_st, input logic [3:0] exp_beats);
    int   req_n       = 0;
    int   frame_n     = 0;
    int   first_frame = -1;
    int   done_idx    = -1;
    exp_t e;
    exp_t got;
    check({name, "_ready_before"}, cmd_ready, 1);
    e.st    = exp_st;
    e.beats = exp_beats;
    sb_q.push_back(e);
    cmd_valid    = 1'b1;
    cmd_len      = 4'(len);
    pci_grnt     = grant;
    pci_frame_in = (busy > 0);
    step();
    cmd_valid = 1'b0;
    cmd_len   = 4'd0;
    for (int k = 1; k <= 60 && done_idx < 0; k++) begin
      pci_frame_in = (k <= busy);
      if (drop_after > 0 && frame_n >= drop_after) pci_grnt = 1'b0;
      if (pci_req) req_n++;
      if (pci_frame) begin
        if (first_frame < 0) first_frame = k;
        frame_n++;
      end
      if (done) begin
        done_idx = k;
        if (sb_q.size() == 0) begin
          check({name, "_unexpected_done"}, 1, 0);
        end else begin
          got = sb_q.pop_front();
          check({name, "_status"}, done_status, got.st);
          check({name, "_beats_left"}, beats_left, got.beats);
        end
        check({name, "_req_low_at_done"}, pci_req, 0);
      end else begin
        step();
      end
    end
    check({name, "_done_seen"}, done_idx > 0, 1);
    check({name, "_done_cycle"}, done_idx, exp_req + 1);
    check({name, "_req_cycles"}, req_n, exp_req);
    check({name, "_frame_cycles"}, frame_n, exp_frame);
    if (exp_frame > 0) check({name, "_frame_start"}, first_frame, busy + 2);
    step();
    check({name, "_done_one_pulse"}, done, 0);
    check({name, "_ready_after"}, cmd_ready, 1);
    pci_grnt     = 1'b0;
    pci_frame_in = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_len      = 4'd0;
    pci_grnt     = 1'b0;
    pci_frame_in = 1'b0;
    step();
    step();
    check("rst_ready", cmd_ready, 1);
    check("rst_req", pci_req, 0);
    check("rst_frame", pci_frame, 0);
    check("rst_done", done, 0);
    check("rst_status", done_status, 0);
    check("rst_beats", beats_left, 0);
    rst = 1'b0;
    step();

    tenure("basic",   4,  1'b1, 0, 0, 5,  4, 2'b00, 4'd0);
    tenure("busy",    3,  1'b1, 3, 0, 7,  3, 2'b00, 4'd0);
    tenure("timeout", 5,  1'b0, 0, 0, 16, 0, 2'b10, 4'd5);
    tenure("preempt", 12, 1'b1, 0, 3, 9,  8, 2'b01, 4'd4);
    tenure("zero",    0,  1'b1, 0, 0, 0,  0, 2'b00, 4'd0);
    tenure("len8",    8,  1'b1, 0, 7, 9,  8, 2'b00, 4'd0);
    tenure("max",     15, 1'b1, 0, 0, 16, 15, 2'b00, 4'd0);

    // Reset in the middle of a transfer, between clock edges.
    cmd_valid = 1'b1;
    cmd_len   = 4'd10;
    pci_grnt  = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("pre_rst_frame", pci_frame, 1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_req", pci_req, 0);
    check("async_rst_frame", pci_frame, 0);
    step();
    check("rst_hold_ready", cmd_ready, 1);
    check("rst_hold_beats", beats_left, 0);
    rst      = 1'b0;
    pci_grnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_no_done", done, 0);
      check("post_rst_no_req", pci_req, 0);
    end
    tenure("after_rst", 2, 1'b1, 0, 0, 3, 2, 2'b00, 4'd0);
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
